// File: rtl/sd_cmd_responder.sv
// SD card command-line responder: receives 48-bit host commands on CMD, checks CRC7,
// and returns an R1-style response after NCR_CYCLES SD-clock falling edges.
module sd_cmd_responder #(
    parameter int unsigned NCR_CYCLES = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_SD_clock,
    input  logic        i_SD_cmd,
    output logic        o_SD_cmd,
    output logic        o_SD_cmd_oe,
    input  logic [31:0] i_card_status,
    output logic        o_cmd_valid,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    output logic        o_crc_error,
    output logic        o_busy
);

    typedef enum logic [2:0] {StIdle, StRx, StCheck, StWait, StTx} state_e;

    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return crc;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  clk_sync_q, cmd_sync_q;
    logic        clk_prev_q;
    logic [46:0] rx_sr_q, rx_sr_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [6:0]  wait_cnt_q, wait_cnt_d;
    logic [47:0] tx_sr_q, tx_sr_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    logic        cmd_out_q, cmd_out_d;
    logic        oe_q, oe_d;
    logic        valid_q, valid_d;
    logic        crc_err_q, crc_err_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] arg_q, arg_d;

    logic        sd_rise, sd_fall, cmd_bit;
    logic [6:0]  rx_crc, tx_crc;

    // Both lines share the same synchronizer depth so a sampled CMD bit lines up with its edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            clk_sync_q <= 2'b00;
            cmd_sync_q <= 2'b11;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], i_SD_clock};
            cmd_sync_q <= {cmd_sync_q[0], i_SD_cmd};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign sd_rise = clk_sync_q[1] & ~clk_prev_q;
    assign sd_fall = ~clk_sync_q[1] & clk_prev_q;
    assign cmd_bit = cmd_sync_q[1];

    // rx_sr holds frame bits 46..0; the start bit (bit 47) is always 0.
    assign rx_crc = crc7({1'b0, rx_sr_q[46:8]});
    assign tx_crc = crc7({2'b00, rx_sr_q[45:40], i_card_status});

    always_comb begin
        state_d    = state_q;
        rx_sr_d    = rx_sr_q;
        rx_cnt_d   = rx_cnt_q;
        wait_cnt_d = wait_cnt_q;
        tx_sr_d    = tx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        cmd_out_d  = cmd_out_q;
        oe_d       = oe_q;
        valid_d    = 1'b0;
        crc_err_d  = 1'b0;
        index_d    = index_q;
        arg_d      = arg_q;
        unique case (state_q)
            StIdle: begin
                if (sd_rise && !cmd_bit) begin
                    state_d  = StRx;
                    rx_sr_d  = '0;
                    rx_cnt_d = 6'd0;
                end
            end
            StRx: begin
                if (sd_rise) begin
                    rx_sr_d = {rx_sr_q[45:0], cmd_bit};
                    if (rx_cnt_q == 6'd46) state_d = StCheck;
                    else                   rx_cnt_d = rx_cnt_q + 6'd1;
                end
            end
            StCheck: begin
                state_d = StIdle;
                if (rx_sr_q[46] && rx_sr_q[0]) begin
                    if (rx_crc != rx_sr_q[7:1]) begin
                        crc_err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        index_d = rx_sr_q[45:40];
                        arg_d   = rx_sr_q[39:8];
                        tx_sr_d = {2'b00, rx_sr_q[45:40], i_card_status, tx_crc, 1'b1};
                        if (rx_sr_q[45:40] != 6'd0) begin
                            state_d    = StWait;
                            wait_cnt_d = 7'd0;
                        end
                    end
                end
            end
            StWait: begin
                if (sd_fall) begin
                    if (wait_cnt_q == 7'(NCR_CYCLES - 1)) begin
                        state_d   = StTx;
                        oe_d      = 1'b1;
                        cmd_out_d = tx_sr_q[47];
                        tx_sr_d   = {tx_sr_q[46:0], 1'b0};
                        tx_cnt_d  = 6'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 7'd1;
                    end
                end
            end
            StTx: begin
                // tx_cnt counts bits driven after the start bit; 47 means the end bit is out.
                if (sd_fall) begin
                    if (tx_cnt_q == 6'd47) begin
                        oe_d      = 1'b0;
                        cmd_out_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        cmd_out_d = tx_sr_q[47];
                        tx_sr_d   = {tx_sr_q[46:0], 1'b0};
                        tx_cnt_d  = tx_cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            rx_sr_q    <= '0;
            rx_cnt_q   <= 6'd0;
            wait_cnt_q <= 7'd0;
            tx_sr_q    <= '0;
            tx_cnt_q   <= 6'd0;
            cmd_out_q  <= 1'b1;
            oe_q       <= 1'b0;
            valid_q    <= 1'b0;
            crc_err_q  <= 1'b0;
            index_q    <= 6'd0;
            arg_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            rx_sr_q    <= rx_sr_d;
            rx_cnt_q   <= rx_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            cmd_out_q  <= cmd_out_d;
            oe_q       <= oe_d;
            valid_q    <= valid_d;
            crc_err_q  <= crc_err_d;
            index_q    <= index_d;
            arg_q      <= arg_d;
        end
    end

    assign o_SD_cmd    = cmd_out_q;
    assign o_SD_cmd_oe = oe_q;
    assign o_cmd_valid = valid_q;
    assign o_crc_error = crc_err_q;
    assign o_cmd_index = index_q;
    assign o_cmd_arg   = arg_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: directed SD command frames plus random commands, compared
// against a polynomial-division CRC model of the command/response protocol.
module tb_sd_cmd_responder;

    logic        clk;
    logic        rst_n;
    logic        sd_clk;
    logic        host_cmd;
    logic        pad;
    logic        card_cmd;
    logic        card_oe;
    logic [31:0] status;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        crc_error;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          valid_cnt = 0;
    int          crc_cnt = 0;
    int          resp_bits = 0;
    logic [47:0] resp = '0;

    assign pad = card_oe ? card_cmd : host_cmd;

    sd_cmd_responder #(.NCR_CYCLES(2)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_SD_clock    (sd_clk),
        .i_SD_cmd      (pad),
        .o_SD_cmd      (card_cmd),
        .o_SD_cmd_oe   (card_oe),
        .i_card_status (status),
        .o_cmd_valid   (cmd_valid),
        .o_cmd_index   (cmd_index),
        .o_cmd_arg     (cmd_arg),
        .o_crc_error   (crc_error),
        .o_busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        sd_clk = 1'b0;
        forever #50 sd_clk = ~sd_clk;
    end

    always @(negedge clk) begin
        if (cmd_valid) valid_cnt++;
        if (crc_error) crc_cnt++;
    end

    // Host samples the card's drive on SD rising edges.
    always @(posedge sd_clk) begin
        if (card_oe) begin
            resp = {resp[46:0], card_cmd};
            resp_bits++;
        end
    end

    // CRC7 as remainder of (data * x^7) divided by x^7 + x^3 + 1.
    function automatic logic [6:0] model_crc(input logic [39:0] data);
        logic [46:0] m;
        m = {data, 7'b0};
        for (int b = 46; b >= 7; b--)
            if (m[b]) m = m ^ (47'h89 << (b - 7));
        return m[6:0];
    endfunction

    function automatic logic [47:0] model_resp(input logic [5:0] idx, input logic [31:0] st);
        return {2'b00, idx, st, model_crc({2'b00, idx, st}), 1'b1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [47:0] frame);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            host_cmd = frame[i];
        end
        @(negedge sd_clk);
        host_cmd = 1'b1;
    endtask

    task automatic run_cmd(input logic [47:0] frame, input logic [31:0] st, input bit check_ncr);
        int v0, c0, r0, n;
        logic crc_ok, exp_valid, exp_crc, exp_resp;
        v0 = valid_cnt;
        c0 = crc_cnt;
        r0 = resp_bits;
        status = st;
        send_frame(frame);
        // Now just past the first SD fall after the end bit; CHECK has already happened.
        #45;
        if (check_ncr) check("ncr_fall1_oe_low", card_oe, 1'b0);
        status = ~st;
        if (check_ncr) begin
            @(negedge sd_clk);
            #45;
            check("ncr_fall2_oe_high", card_oe, 1'b1);
            check("ncr_start_bit", card_cmd, 1'b0);
        end
        n = 0;
        while (busy && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
        #100;
        crc_ok    = (model_crc(frame[47:8]) == frame[7:1]);
        exp_valid = frame[46] && frame[0] && crc_ok;
        exp_crc   = frame[46] && frame[0] && !crc_ok;
        exp_resp  = exp_valid && (frame[45:40] != 6'd0);
        check("valid_pulses", 64'(valid_cnt - v0), 64'(exp_valid));
        check("crc_error_pulses", 64'(crc_cnt - c0), 64'(exp_crc));
        check("resp_bit_count", 64'(resp_bits - r0), exp_resp ? 64'd48 : 64'd0);
        check("oe_released", card_oe, 1'b0);
        if (exp_valid) begin
            check("cmd_index", cmd_index, frame[45:40]);
            check("cmd_arg", cmd_arg, frame[39:8]);
        end
        if (exp_resp) check("response", resp, model_resp(frame[45:40], st));
    endtask

    initial begin
        int n, r0;
        logic [5:0]  idx;
        logic [31:0] arg, st;
        logic [6:0]  crc;
        logic        tbit;
        logic [47:0] frame;

        rst_n    = 1'b1;
        host_cmd = 1'b1;
        status   = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_oe", card_oe, 1'b0);
        check("rst_cmd", card_cmd, 1'b1);
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_crc_error", crc_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_index", cmd_index, 6'd0);
        check("rst_arg", cmd_arg, 32'd0);
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        #300;

        run_cmd(48'h400000000095, 32'h0, 1'b0);
        run_cmd(48'h770000000065, 32'h00000120, 1'b1);
        check("cmd55_resp_value", resp, 48'h370000012083);
        run_cmd(48'h48000001AA87, 32'h000001AA, 1'b0);
        check("cmd8_resp_head", resp[47:8], 40'h08000001AA);
        run_cmd(48'h400000000097, 32'h0, 1'b0);
        run_cmd(48'h370000012083, 32'h0, 1'b0);

        // Reset in the middle of a response, then a fresh CMD0.
        r0 = resp_bits;
        status = 32'h00000120;
        send_frame(48'h770000000065);
        n = 0;
        while ((resp_bits - r0) < 20 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("rst_bit20_reached", 64'(resp_bits - r0), 64'd20);
        #3 rst_n = 1'b0;
        #1;
        check("midtx_rst_oe", card_oe, 1'b0);
        check("midtx_rst_cmd", card_cmd, 1'b1);
        check("midtx_rst_busy", busy, 1'b0);
        check("midtx_rst_index", cmd_index, 6'd0);
        #200;
        @(negedge clk);
        rst_n = 1'b1;
        #300;
        run_cmd(48'h400000000095, 32'h0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            idx  = 6'($urandom_range(0, 63));
            arg  = $urandom;
            st   = $urandom;
            tbit = ($urandom_range(0, 7) != 0);
            crc  = model_crc({1'b0, tbit, idx, arg});
            if ($urandom_range(0, 3) == 0) crc = crc ^ 7'(1 << $urandom_range(0, 6));
            frame = {1'b0, tbit, idx, arg, crc, 1'b1};
            run_cmd(frame, st, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 SHALL have parameter NCR_CYCLES, default 2: number of SD-clock falling edges from the command end bit to the response start bit, legal range 1..64.
REQ-002 SHALL have port i_clock, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port i_SD_clock, input, 1: SD clock from host; asynchronous to i_clock, at most i_clock/8.
REQ-005 SHALL have port i_SD_cmd, input, 1: CMD line as seen at the pad (host drives it).
REQ-006 SHALL have port o_SD_cmd, output, 1: CMD value driven by this card.
REQ-007 SHALL have port o_SD_cmd_oe, output, 1: pad output enable; 1 = drive o_SD_cmd, 0 = high-Z.
REQ-008 SHALL have port i_card_status, input, 32: status word returned in every R1 response.
REQ-009 SHALL have port o_cmd_valid, output, 1: one-i_clock pulse per accepted command.
REQ-010 SHALL have port o_cmd_index, output, 6: index of the last accepted command.
REQ-011 SHALL have port o_cmd_arg, output, 32: argument of the last accepted command.
REQ-012 SHALL have port o_crc_error, output, 1: one-i_clock pulse per frame rejected for CRC.
REQ-013 SHALL have port o_busy, output, 1: high from start-bit detection until return to IDLE.

Function
REQ-014 SHALL pass i_SD_clock and i_SD_cmd through matching 2-flop synchronizers and derive one-cycle rise/fall events from the synchronized clock.
REQ-015 SHALL sample CMD only on rise events and change o_SD_cmd/o_SD_cmd_oe only on fall events.
REQ-016 SHALL use FSM states IDLE, RX, CHECK, WAIT, TX.
REQ-017 IDLE: a rise event with sampled CMD=0 SHALL be the start bit; go to RX and set o_busy.
REQ-018 RX: shift in the remaining 47 bits MSB-first on rise events, then go to CHECK.
REQ-019 Frame format SHALL be start 0, transmission bit, index[5:0], arg[31:0], CRC7[6:0], end bit.
REQ-020 CRC7 SHALL use polynomial x^7+x^3+1, initial value 0, over the first 40 frame bits.
REQ-021 CHECK (one i_clock): if the transmission bit is 0 or the end bit is 0, go to IDLE with no pulses.
REQ-022 CHECK: else on CRC mismatch, pulse o_crc_error and go to IDLE with no response.
REQ-023 CHECK: else pulse o_cmd_valid, update o_cmd_index/o_cmd_arg in the same cycle, and latch i_card_status.
REQ-024 CHECK: on a valid command with index 0, go to IDLE (no response); for any other index, go to WAIT.
REQ-025 WAIT: count fall events; on the NCR_CYCLES-th, set o_SD_cmd_oe=1, drive the start bit, and go to TX.
REQ-026 Response frame SHALL be 0, 0, echoed index, latched status[31:0], CRC7 over the first 40 bits, 1; one bit per fall event, MSB-first.
REQ-027 TX: on the fall event after the end bit, set o_SD_cmd_oe=0 and o_SD_cmd=1, and go to IDLE.
REQ-028 Incoming CMD SHALL be ignored in CHECK, WAIT and TX.
REQ-029 i_card_status changes after CHECK SHALL NOT affect an in-flight response.
REQ-030 A rise and a fall event SHALL never coincide; no other simultaneous-event cases exist.

Reset
REQ-031 On i_reset_n=0, immediately: state IDLE, o_SD_cmd_oe=0, o_SD_cmd=1, o_cmd_valid=0, o_crc_error=0, o_busy=0, o_cmd_index=0, o_cmd_arg=0, counters and shift registers cleared.
REQ-032 Reset asserted mid-RX, mid-WAIT or mid-TX SHALL abort the frame; after release, only a new start bit is recognised.

Verification
REQ-033 CMD0 frame 0x400000000095 -> o_cmd_valid pulse, index 0, arg 0; o_SD_cmd_oe stays 0.
REQ-034 CMD55 frame 0x770000000065, i_card_status=0x00000120 -> index 55, arg 0; start bit driven on the 2nd SD falling edge after the end bit; response 0x370000012083.
REQ-035 CMD8 frame 0x48000001AA87, i_card_status=0x000001AA -> index 8, arg 0x000001AA; response bits 47..8 = 0x08000001AA; CRC matches the model.
REQ-036 CMD0 with bad CRC (0x400000000097) -> one o_crc_error pulse, no o_cmd_valid, no drive.
REQ-037 Frame with transmission bit 0 (0x370000012083 driven by host) -> no pulses, no response, o_busy falls after CHECK.
REQ-038 Reset asserted at response bit 20 of REQ-034 -> o_SD_cmd_oe=0 and o_SD_cmd=1 immediately; a following CMD0 is accepted normally.
